// File: rtl/bridge_pkg.sv
// bridge_pkg
//   Shared definitions for the drawbridge plant model: the deck-state
//   encoding (identical to the controller's Flat/Lifting/Upright/Lowering
//   encoding), default timing constants and a small counter helper.
// Ports: none (package).
package bridge_pkg;

  typedef logic [1:0] deck_state_t;

  localparam deck_state_t DK_DOWN    = 2'b00;
  localparam deck_state_t DK_RISING  = 2'b01;
  localparam deck_state_t DK_UP      = 2'b10;
  localparam deck_state_t DK_FALLING = 2'b11;

  localparam int unsigned TRAVEL_CYCLES_DEF = 32'd16;
  localparam int unsigned CROSS_CYCLES_DEF  = 32'd8;
  localparam int unsigned BOAT_CYCLES_DEF   = 32'd12;
  localparam int unsigned MAX_CARS_DEF      = 32'd4;
  localparam int unsigned PW_DEF            = 32'd5;

  // Up/down step of the deck occupancy; simultaneous entry and exit cancel.
  function automatic logic [2:0] count_step(input logic [2:0] count,
                                            input logic inc,
                                            input logic dec);
    logic [2:0] r;
    if (inc && !dec) begin
      r = count + 3'd1;
    end else if (dec && !inc) begin
      r = count - 3'd1;
    end else begin
      r = count;
    end
    return r;
  endfunction

endpackage

// File: rtl/car_lane_model.sv
// car_lane_model
//   Car side of the plant: decides whether an arriving car may enter the
//   deck, times each car across the deck with a shift register and keeps
//   the occupancy count.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   tfl            traffic light, 0 = green
//   deck_flat      deck is down and at position 0
//   car_req        1-clock car arrival pulse
//   cain, cao      registered car-in / car-out pulses
//   reject         registered pulse for a refused arrival
//   cars_on_deck   registered occupancy count
module car_lane_model
  import bridge_pkg::*;
#(
  parameter int unsigned CROSS_CYCLES = CROSS_CYCLES_DEF,
  parameter int unsigned MAX_CARS     = MAX_CARS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tfl,
  input  logic       deck_flat,
  input  logic       car_req,
  output logic       cain,
  output logic       cao,
  output logic       reject,
  output logic [2:0] cars_on_deck
);

  localparam logic [2:0] MAX_C = 3'(MAX_CARS);

  // Stage 0 is the CAIN pulse, stage CROSS_CYCLES is the CAO pulse, so every
  // car leaves exactly CROSS_CYCLES clocks after it entered.
  logic [CROSS_CYCLES:0] lane_r;
  logic [2:0]            count_r;
  logic                  reject_r;
  logic                  admit_s;
  logic                  leave_s;

  // Admission check against the occupancy before this edge.
  always_comb begin
    admit_s = 1'b0;
    if (car_req && !tfl && deck_flat && (count_r < MAX_C)) begin
      admit_s = 1'b1;
    end else begin
      admit_s = 1'b0;
    end
  end

  assign leave_s = lane_r[CROSS_CYCLES-1];

  // Crossing pipeline, occupancy counter and reject pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_r   <= {(CROSS_CYCLES+1){1'b0}};
      count_r  <= 3'd0;
      reject_r <= 1'b0;
    end else begin
      lane_r   <= {lane_r[CROSS_CYCLES-1:0], admit_s};
      count_r  <= count_step(count_r, admit_s, leave_s);
      reject_r <= car_req && !admit_s;
    end
  end

  assign cain         = lane_r[0];
  assign cao          = lane_r[CROSS_CYCLES];
  assign reject       = reject_r;
  assign cars_on_deck = count_r;

endmodule

// File: rtl/bridge_plant_model.sv
// bridge_plant_model
//   Cycle-accurate drawbridge plant: moves the deck under the motor
//   command, lets cars cross and boats pass, and flags unsafe operation.
// Ports:
//   Clk, Reset        clock, asynchronous active-low reset
//   MT, TFL           motor enable and traffic light from the controller
//   CarReq, BoatReq   1-clock arrival pulses
//   CAIN, CAO         car entered / left the deck (1-clock pulses)
//   BS                boat waiting or passing
//   H, L              high / low limit switches decoded from Pos
//   Pos               deck position, 0 = flat
//   CarsOnDeck        deck occupancy
//   Reject            refused car arrival (1-clock pulse)
//   Fault             sticky safety violation
module bridge_plant_model
  import bridge_pkg::*;
#(
  parameter int unsigned TRAVEL_CYCLES = TRAVEL_CYCLES_DEF,
  parameter int unsigned CROSS_CYCLES  = CROSS_CYCLES_DEF,
  parameter int unsigned BOAT_CYCLES   = BOAT_CYCLES_DEF,
  parameter int unsigned MAX_CARS      = MAX_CARS_DEF,
  parameter int unsigned PW            = PW_DEF
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          MT,
  input  logic          TFL,
  input  logic          CarReq,
  input  logic          BoatReq,
  output logic          CAIN,
  output logic          CAO,
  output logic          BS,
  output logic          H,
  output logic          L,
  output logic [PW-1:0] Pos,
  output logic [2:0]    CarsOnDeck,
  output logic          Reject,
  output logic          Fault
);

  localparam int unsigned TW = $clog2(BOAT_CYCLES + 1);
  localparam logic [PW-1:0] POS_TOP   = PW'(TRAVEL_CYCLES);
  localparam logic [PW-1:0] POS_ONE   = PW'(1);
  localparam logic [PW-1:0] POS_ZERO  = PW'(0);
  localparam logic [PW-1:0] WAIT_LAST = PW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] BOAT_LAST = TW'(BOAT_CYCLES - 1);
  localparam logic [TW-1:0] TMR_ZERO  = TW'(0);
  localparam logic [TW-1:0] TMR_ONE   = TW'(1);

  deck_state_t   state_r, state_next_s;
  logic [PW-1:0] pos_r, pos_next_s;
  logic          bs_r, bs_next_s;
  logic [TW-1:0] timer_r, timer_next_s;
  logic [PW-1:0] wait_r, wait_next_s;
  logic          fault_r, fault_next_s;
  logic          deck_up_s, deck_flat_s;
  logic          car_move_s, boat_intr_s, wait_expired_s;
  logic [2:0]    cars_s;

  assign deck_up_s   = (state_r == DK_UP);
  assign deck_flat_s = (state_r == DK_DOWN) && (pos_r == POS_ZERO);

  car_lane_model #(
    .CROSS_CYCLES (CROSS_CYCLES),
    .MAX_CARS     (MAX_CARS)
  ) u_lane (
    .clk          (Clk),
    .rst_n        (Reset),
    .tfl          (TFL),
    .deck_flat    (deck_flat_s),
    .car_req      (CarReq),
    .cain         (CAIN),
    .cao          (CAO),
    .reject       (Reject),
    .cars_on_deck (cars_s)
  );

  // Deck travel: each MT-high clock moves the deck one step; the range
  // checks make Pos saturate at both ends.
  always_comb begin
    state_next_s = state_r;
    pos_next_s   = pos_r;
    if (MT) begin
      case (state_r)
        DK_DOWN: begin
          pos_next_s   = POS_ONE;
          state_next_s = DK_RISING;
        end
        DK_RISING: begin
          if (pos_r >= POS_TOP - POS_ONE) begin
            pos_next_s   = POS_TOP;
            state_next_s = DK_UP;
          end else begin
            pos_next_s   = pos_r + POS_ONE;
            state_next_s = DK_RISING;
          end
        end
        DK_UP: begin
          pos_next_s   = POS_TOP - POS_ONE;
          state_next_s = DK_FALLING;
        end
        DK_FALLING: begin
          if (pos_r <= POS_ONE) begin
            pos_next_s   = POS_ZERO;
            state_next_s = DK_DOWN;
          end else begin
            pos_next_s   = pos_r - POS_ONE;
            state_next_s = DK_FALLING;
          end
        end
        default: begin
          pos_next_s   = pos_r;
          state_next_s = state_r;
        end
      endcase
    end else begin
      pos_next_s   = pos_r;
      state_next_s = state_r;
    end
  end

  assign car_move_s     = (pos_next_s != pos_r) && (cars_s != 3'd0);
  assign boat_intr_s    = bs_r && deck_up_s && MT && (timer_r != TMR_ZERO);
  assign wait_expired_s = bs_r && !deck_up_s && (wait_r == WAIT_LAST);

  // Boat passage timer, boat-wait watchdog and fault accumulation.
  always_comb begin
    bs_next_s    = bs_r;
    timer_next_s = timer_r;
    wait_next_s  = wait_r;
    fault_next_s = fault_r | car_move_s | boat_intr_s | wait_expired_s;
    if (bs_r && deck_up_s && !MT) begin
      if (timer_r == BOAT_LAST) begin
        timer_next_s = TMR_ZERO;
        bs_next_s    = 1'b0;
      end else begin
        timer_next_s = timer_r + TMR_ONE;
        bs_next_s    = 1'b1;
      end
    end else if (bs_r) begin
      // Deck leaving or away from Upright: the boat keeps waiting.
      timer_next_s = TMR_ZERO;
      bs_next_s    = 1'b1;
    end else begin
      timer_next_s = TMR_ZERO;
      bs_next_s    = BoatReq;
    end
    if (bs_r && !deck_up_s) begin
      wait_next_s = (wait_r == WAIT_LAST) ? wait_r : wait_r + POS_ONE;
    end else begin
      wait_next_s = POS_ZERO;
    end
  end

  // Plant state registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r <= DK_DOWN;
      pos_r   <= POS_ZERO;
      bs_r    <= 1'b0;
      timer_r <= TMR_ZERO;
      wait_r  <= POS_ZERO;
      fault_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      pos_r   <= pos_next_s;
      bs_r    <= bs_next_s;
      timer_r <= timer_next_s;
      wait_r  <= wait_next_s;
      fault_r <= fault_next_s;
    end
  end

  assign Pos        = pos_r;
  assign H          = (pos_r == POS_TOP);
  assign L          = (pos_r == POS_ZERO);
  assign BS         = bs_r;
  assign Fault      = fault_r;
  assign CarsOnDeck = cars_s;

endmodule

// File: tb/tb_bridge_plant_model.sv
// tb_bridge_plant_model
//   Directed and randomized stimulus for bridge_plant_model, checked against
//   a behavioural model: the deck is an integer position plus a direction,
//   cars are a queue of exit cycle numbers, boats are simple counters.
module tb_bridge_plant_model;

  localparam int T  = 16;
  localparam int C  = 8;
  localparam int B  = 12;
  localparam int M  = 4;
  localparam int PW = 5;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          MT = 1'b0, TFL = 1'b0, CarReq = 1'b0, BoatReq = 1'b0;
  logic          CAIN, CAO, BS, H, L, Reject, Fault;
  logic [PW-1:0] Pos;
  logic [2:0]    CarsOnDeck;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int m_pos;
  bit m_dir_up;
  int m_lane[$];
  bit m_cain, m_cao, m_reject, m_bs, m_fault;
  int m_boat, m_wait;
  int cyc = 0;

  always #5 Clk = ~Clk;

  bridge_plant_model dut (
    .Clk(Clk), .Reset(Reset), .MT(MT), .TFL(TFL), .CarReq(CarReq),
    .BoatReq(BoatReq), .CAIN(CAIN), .CAO(CAO), .BS(BS), .H(H), .L(L),
    .Pos(Pos), .CarsOnDeck(CarsOnDeck), .Reject(Reject), .Fault(Fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_dir_up = 1'b0; m_lane.delete();
    m_cain = 1'b0; m_cao = 1'b0; m_reject = 1'b0;
    m_bs = 1'b0; m_fault = 1'b0; m_boat = 0; m_wait = 0;
  endtask

  task automatic model_edge();
    int  prev_cnt;
    bit  prev_up, prev_flat;
    prev_cnt  = m_lane.size();
    prev_up   = (m_pos == T);
    prev_flat = (m_pos == 0);
    cyc++;
    m_cao = 1'b0;
    if (m_lane.size() > 0 && m_lane[0] == cyc) begin
      void'(m_lane.pop_front());
      m_cao = 1'b1;
    end
    m_cain = 1'b0; m_reject = 1'b0;
    if (CarReq) begin
      if (!TFL && prev_flat && prev_cnt < M) begin
        m_cain = 1'b1;
        m_lane.push_back(cyc + C);
      end else begin
        m_reject = 1'b1;
      end
    end
    if (MT && prev_cnt != 0) m_fault = 1'b1;
    if (m_bs) begin
      if (prev_up) begin
        m_wait = 0;
        if (MT) begin
          if (m_boat > 0) m_fault = 1'b1;
          m_boat = 0;
        end else begin
          m_boat++;
          if (m_boat == B) begin m_bs = 1'b0; m_boat = 0; end
        end
      end else begin
        m_wait++;
        if (m_wait >= T) m_fault = 1'b1;
      end
    end else begin
      m_wait = 0;
      if (BoatReq) m_bs = 1'b1;
    end
    if (MT) begin
      if (m_pos == 0) begin m_pos = 1; m_dir_up = 1'b1; end
      else if (m_pos == T) begin m_pos = T - 1; m_dir_up = 1'b0; end
      else m_pos += m_dir_up ? 1 : -1;
    end
  endtask

  task automatic check_all();
    check("CAIN", CAIN, m_cain);
    check("CAO", CAO, m_cao);
    check("Reject", Reject, m_reject);
    check("CarsOnDeck", CarsOnDeck, m_lane.size());
    check("Pos", Pos, m_pos);
    check("H", H, m_pos == T);
    check("L", L, m_pos == 0);
    check("BS", BS, m_bs);
    check("Fault", Fault, m_fault);
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    MT = 1'b0; TFL = 1'b0; CarReq = 1'b0; BoatReq = 1'b0;
    #1 Reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  initial begin
    bit saw_cao;

    // 1: full lift, then hold
    do_reset();
    check("t1_reset_L", L, 1'b1);
    MT = 1'b1;
    step();
    check("t1_L_falls", L, 1'b0);
    for (int i = 0; i < T - 1; i++) step();
    check("t1_top_pos", Pos, 32'd16);
    check("t1_top_H", H, 1'b1);
    MT = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("t1_hold_pos", Pos, 32'd16);

    // 2: single car crossing
    do_reset();
    for (int i = 0; i < 9; i++) step();
    CarReq = 1'b1; step(); CarReq = 1'b0;
    check("t2_cain", CAIN, 1'b1);
    check("t2_count1", CarsOnDeck, 32'd1);
    for (int i = 0; i < C - 1; i++) step();
    step();
    check("t2_cao", CAO, 1'b1);
    check("t2_count0", CarsOnDeck, 32'd0);

    // 3: capacity and simultaneous entry/exit
    do_reset();
    CarReq = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("t3_reject5", Reject, 1'b1);
    check("t3_peak", CarsOnDeck, 32'd4);
    CarReq = 1'b0;
    for (int i = 0; i < 4; i++) step();
    CarReq = 1'b1; step(); CarReq = 1'b0;
    check("t3_both_cain", CAIN, 1'b1);
    check("t3_both_cao", CAO, 1'b1);
    check("t3_both_count", CarsOnDeck, 32'd3);
    for (int i = 0; i < 12; i++) step();

    // 4: boat passage
    do_reset();
    BoatReq = 1'b1; MT = 1'b1; step(); BoatReq = 1'b0;
    for (int i = 0; i < T - 1; i++) step();
    MT = 1'b0;
    for (int i = 0; i < B - 1; i++) step();
    check("t4_bs_11", BS, 1'b1);
    step();
    check("t4_bs_12", BS, 1'b0);
    check("t4_fault", Fault, 1'b0);

    // 5: deck moves with a car on it
    do_reset();
    CarReq = 1'b1; step(); CarReq = 1'b0;
    MT = 1'b1; step(); MT = 1'b0;
    check("t5_pos", Pos, 32'd1);
    check("t5_fault", Fault, 1'b1);
    for (int i = 0; i < 5; i++) step();
    check("t5_sticky", Fault, 1'b1);
    do_reset();
    check("t5_cleared", Fault, 1'b0);

    // 6: reset mid-travel with cars crossing
    do_reset();
    CarReq = 1'b1; step();
    MT = 1'b1; step(); CarReq = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("t6_pos7", Pos, 32'd7);
    check("t6_cars2", CarsOnDeck, 32'd2);
    do_reset();
    check("t6_pos0", Pos, 32'd0);
    check("t6_L", L, 1'b1);
    check("t6_cars0", CarsOnDeck, 32'd0);
    saw_cao = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      saw_cao |= CAO;
    end
    check("t6_no_cao", saw_cao, 1'b0);

    // randomized traffic
    for (int blk = 0; blk < 6; blk++) begin
      do_reset();
      for (int i = 0; i < 70; i++) begin
        MT      = ($urandom_range(99) < 20 + blk * 10);
        TFL     = ($urandom_range(99) < 40);
        CarReq  = ($urandom_range(99) < 25);
        BoatReq = ($urandom_range(99) < 10);
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
